// File: rtl/multi_button_monitor.sv
// Multi-channel button monitor: per-channel synchroniser, stable-time debounce FSM,
// long-press detector and press/raw-bounce counters.
module multi_button_monitor #(
  parameter int CHANNELS        = 4,
  parameter int CNT_BITS        = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int LONG_CYCLES     = 1000,
  parameter int SATURATE        = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          button_in,
  input  logic                         clear,
  output logic [CHANNELS-1:0]          debounced,
  output logic [CHANNELS-1:0]          press_tick,
  output logic [CHANNELS-1:0]          long_tick,
  output logic [CHANNELS*CNT_BITS-1:0] press_count,
  output logic [CHANNELS*CNT_BITS-1:0] bounce_count
);

  localparam int TW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [TW-1:0] DB_LAST   = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_e;

  function automatic logic [CNT_BITS-1:0] inc_cnt(input logic [CNT_BITS-1:0] c);
    if ((SATURATE != 0) && (&c)) return c;
    return c + CNT_BITS'(1);
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    db_state_e           state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                deb_q, deb_d;
    logic                ptick_q, ptick_d;
    logic                ltick_q, ltick_d;
    logic [CNT_BITS-1:0] pcnt_q, pcnt_d;
    logic [CNT_BITS-1:0] bcnt_q, bcnt_d;
    logic                meta_q, meta_d;
    logic                sync_q, sync_d;
    logic                sync_dly_q, sync_dly_d;
    logic                raw_edge;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q    <= STABLE_LO;
        timer_q    <= '0;
        hold_q     <= '0;
        deb_q      <= 1'b0;
        ptick_q    <= 1'b0;
        ltick_q    <= 1'b0;
        pcnt_q     <= '0;
        bcnt_q     <= '0;
        meta_q     <= 1'b0;
        sync_q     <= 1'b0;
        sync_dly_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        timer_q    <= timer_d;
        hold_q     <= hold_d;
        deb_q      <= deb_d;
        ptick_q    <= ptick_d;
        ltick_q    <= ltick_d;
        pcnt_q     <= pcnt_d;
        bcnt_q     <= bcnt_d;
        meta_q     <= meta_d;
        sync_q     <= sync_d;
        sync_dly_q <= sync_dly_d;
      end
    end

    assign raw_edge = sync_q & ~sync_dly_q;

    always_comb begin
      meta_d     = button_in[i];
      sync_d     = meta_q;
      sync_dly_d = sync_q;
      state_d    = state_q;
      timer_d    = timer_q;
      deb_d      = deb_q;
      ptick_d    = 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (sync_q) begin
            state_d = WAIT_HI;
            timer_d = TW'(1);
          end
        end
        WAIT_HI: begin
          if (!sync_q) begin
            state_d = STABLE_LO;
            timer_d = '0;
          end else if (timer_q == DB_LAST) begin
            state_d = STABLE_HI;
            timer_d = '0;
            deb_d   = 1'b1;
            ptick_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        STABLE_HI: begin
          if (!sync_q) begin
            state_d = WAIT_LO;
            timer_d = TW'(1);
          end
        end
        WAIT_LO: begin
          // A return to high here is bounce on release, not a new press.
          if (sync_q) begin
            state_d = STABLE_HI;
            timer_d = '0;
          end else if (timer_q == DB_LAST) begin
            state_d = STABLE_LO;
            timer_d = '0;
            deb_d   = 1'b0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = STABLE_LO;
          timer_d = '0;
        end
      endcase
    end

    // Hold timer saturates at LONG_CYCLES so long_tick fires only once per press.
    always_comb begin
      hold_d  = hold_q;
      ltick_d = 1'b0;
      if ((state_q == WAIT_HI) && (state_d == STABLE_HI)) begin
        hold_d = '0;
      end else if (deb_q) begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
        ltick_d = (hold_q == HOLD_LAST);
      end else begin
        hold_d = '0;
      end
    end

    always_comb begin
      pcnt_d = pcnt_q;
      bcnt_d = bcnt_q;
      if (clear) begin
        pcnt_d = '0;
        bcnt_d = '0;
      end else begin
        if (ptick_q)  pcnt_d = inc_cnt(pcnt_q);
        if (raw_edge) bcnt_d = inc_cnt(bcnt_q);
      end
    end

    assign debounced[i]                           = deb_q;
    assign press_tick[i]                          = ptick_q;
    assign long_tick[i]                           = ltick_q;
    assign press_count[i*CNT_BITS +: CNT_BITS]    = pcnt_q;
    assign bounce_count[i*CNT_BITS +: CNT_BITS]   = bcnt_q;
  end

endmodule

// File: tb/tb_multi_button_monitor.sv
// Directed bench for multi_button_monitor: wrapping and saturating instances share stimulus;
// expectations are queued when stimulus is driven and popped when outputs are sampled.
module tb_multi_button_monitor;
  localparam int CH = 4;
  localparam int CB = 4;
  localparam int DB = 4;
  localparam int LC = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic [CH-1:0] button_in = '0;
  logic [CH-1:0] deb_a, pt_a, lt_a, deb_b, pt_b, lt_b;
  logic [CH*CB-1:0] pc_a, bc_a, pc_b, bc_b;

  always #5 clk = ~clk;

  multi_button_monitor #(.CHANNELS(CH), .CNT_BITS(CB), .DEBOUNCE_CYCLES(DB),
                         .LONG_CYCLES(LC), .SATURATE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .button_in(button_in), .clear(clear),
    .debounced(deb_a), .press_tick(pt_a), .long_tick(lt_a),
    .press_count(pc_a), .bounce_count(bc_a));

  multi_button_monitor #(.CHANNELS(CH), .CNT_BITS(CB), .DEBOUNCE_CYCLES(DB),
                         .LONG_CYCLES(LC), .SATURATE(1)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .button_in(button_in), .clear(clear),
    .debounced(deb_b), .press_tick(pt_b), .long_tick(lt_b),
    .press_count(pc_b), .bounce_count(bc_b));

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int ptick_n[CH];
  int ptick_edge[CH];
  int ltick_n[CH];
  int ltick_edge[CH];
  int deb_rise[CH];
  logic [CH-1:0] deb_prev = '0;

  typedef struct {string tag; int exp;} exp_t;
  exp_t sb[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  // Tick/edge monitor for the wrapping instance.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (pt_a[c] === 1'b1) begin ptick_n[c]++; ptick_edge[c] = edge_n; end
      if (lt_a[c] === 1'b1) begin ltick_n[c]++; ltick_edge[c] = edge_n; end
      if (deb_a[c] === 1'b1 && deb_prev[c] !== 1'b1) deb_rise[c] = edge_n;
    end
    deb_prev = deb_a;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int fld(input logic [CH*CB-1:0] v, input int c);
    return int'(v[c*CB +: CB]);
  endfunction

  task automatic wait_edge(input int t);
    while (edge_n < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_v(input int obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0d expected none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    int k, k2, r;
    wait_edge(3);
    expect_v("rst_debounced", 0);
    expect_v("rst_press_tick", 0);
    expect_v("rst_long_tick", 0);
    expect_v("rst_press_count", 0);
    expect_v("rst_bounce_count", 0);
    check_v(int'(deb_a | deb_b));
    check_v(int'(pt_a | pt_b));
    check_v(int'(lt_a | lt_b));
    check_v(int'(pc_a | pc_b));
    check_v(int'(bc_a | bc_b));
    reset_n = 1'b1;
    wait_edge(5);

    // ch0 clean press: latency of bounce count, debounced and press_tick
    k = edge_n; button_in[0] = 1'b1;
    expect_v("ch0_bounce_edge2", 0);
    expect_v("ch0_bounce_edge3", 1);
    expect_v("ch0_deb_edge5", 0);
    expect_v("ch0_press_edge", k + 6);
    expect_v("ch0_deb_rise_edge", k + 6);
    expect_v("ch0_press_count", 1);
    wait_edge(k + 2); check_v(fld(bc_a, 0));
    wait_edge(k + 3); check_v(fld(bc_a, 0));
    wait_edge(k + 5); check_v(int'(deb_a[0]));
    wait_edge(k + 7); check_v(ptick_edge[0]); check_v(deb_rise[0]); check_v(fld(pc_a, 0));

    // ch0 release latency
    k = edge_n; button_in[0] = 1'b0;
    expect_v("ch0_deb_release_edge5", 1);
    expect_v("ch0_deb_release_edge6", 0);
    expect_v("ch0_press_ticks", 1);
    expect_v("ch0_short_no_long", 0);
    wait_edge(k + 5); check_v(int'(deb_a[0]));
    wait_edge(k + 6); check_v(int'(deb_a[0])); check_v(ptick_n[0]); check_v(ltick_n[0]);

    // ch1 three 2-cycle glitches then stable high
    expect_v("ch1_glitch_presses", 0);
    for (int g = 0; g < 3; g++) begin
      button_in[1] = 1'b1; wait_edge(edge_n + 2);
      button_in[1] = 1'b0; wait_edge(edge_n + 2);
    end
    wait_edge(edge_n + 4);
    check_v(ptick_n[1]);
    k = edge_n; button_in[1] = 1'b1;
    expect_v("ch1_press_edge", k + 6);
    expect_v("ch1_press_ticks", 1);
    expect_v("ch1_press_count", 1);
    expect_v("ch1_bounce_count", 4);
    wait_edge(k + 8);
    check_v(ptick_edge[1]); check_v(ptick_n[1]); check_v(fld(pc_a, 1)); check_v(fld(bc_a, 1));
    button_in[1] = 1'b0;
    wait_edge(edge_n + 8);

    // ch2 long press held 30 cycles
    k = edge_n; button_in[2] = 1'b1;
    expect_v("ch2_no_long_early", 0);
    expect_v("ch2_press_edge", k + 6);
    expect_v("ch2_long_edge", k + 16);
    expect_v("ch2_long_count", 1);
    wait_edge(k + 15); check_v(ltick_n[2]);
    wait_edge(k + 30); check_v(ptick_edge[2]); check_v(ltick_edge[2]); check_v(ltick_n[2]);
    button_in[2] = 1'b0;
    wait_edge(edge_n + 10);

    // ch2 held 5 cycles: press, no long press
    k = edge_n; button_in[2] = 1'b1;
    expect_v("ch2_short_presses", 2);
    expect_v("ch2_short_long_count", 1);
    wait_edge(k + 5); button_in[2] = 1'b0;
    wait_edge(k + 16); check_v(ptick_n[2]); check_v(ltick_n[2]);

    // ch2 3-cycle pulse: below debounce window
    k = edge_n; button_in[2] = 1'b1;
    expect_v("ch2_pulse_deb", 0);
    expect_v("ch2_pulse_presses", 2);
    expect_v("ch2_pulse_bounce", 3);
    wait_edge(k + 3); button_in[2] = 1'b0;
    wait_edge(k + 6); check_v(int'(deb_a[2]));
    wait_edge(k + 12); check_v(ptick_n[2]); check_v(fld(bc_a, 2));

    // ch3 seventeen clean presses: wrap vs saturate
    expect_v("ch3_ticks", 17);
    expect_v("ch3_wrap_press", 1);
    expect_v("ch3_sat_press", 15);
    expect_v("ch3_wrap_bounce", 1);
    expect_v("ch3_sat_bounce", 15);
    for (int p = 0; p < 17; p++) begin
      button_in[3] = 1'b1; wait_edge(edge_n + 8);
      button_in[3] = 1'b0; wait_edge(edge_n + 8);
    end
    check_v(ptick_n[3]);
    check_v(fld(pc_a, 3)); check_v(fld(pc_b, 3));
    check_v(fld(bc_a, 3)); check_v(fld(bc_b, 3));

    // clear coincident with press_tick on ch0
    k = edge_n; button_in[0] = 1'b1;
    expect_v("clr_tick_edge", k + 6);
    expect_v("clr_press_count", 0);
    expect_v("clr_deb_kept", 1);
    expect_v("clr_sat_bounce", 0);
    expect_v("clr_ch2_bounce", 0);
    wait_edge(k + 6); clear = 1'b1;
    wait_edge(k + 7); clear = 1'b0;
    check_v(ptick_edge[0]); check_v(fld(pc_a, 0)); check_v(int'(deb_a[0]));
    check_v(fld(bc_b, 3)); check_v(fld(bc_a, 2));
    button_in[0] = 1'b0;
    wait_edge(edge_n + 10);

    // reset mid-WAIT_HI on ch0 while ch1 is debounced high
    k = edge_n; button_in[1] = 1'b1;
    wait_edge(k + 8);
    k2 = edge_n; button_in[0] = 1'b1;
    wait_edge(k2 + 4);
    expect_v("mid_rst_debounced", 0);
    expect_v("mid_rst_press_count", 0);
    expect_v("mid_rst_bounce_count", 0);
    reset_n = 1'b0;
    #1;
    check_v(int'(deb_a)); check_v(int'(pc_a)); check_v(int'(bc_a));
    @(negedge clk); @(negedge clk); #1;
    r = edge_n; reset_n = 1'b1;
    expect_v("rel_ch0_press_edge", r + 6);
    expect_v("rel_ch1_press_edge", r + 6);
    expect_v("rel_ch0_press_count", 1);
    expect_v("rel_ch0_bounce_count", 1);
    expect_v("rel_ch0_ticks", 3);
    expect_v("rel_ch1_no_long", 0);
    wait_edge(r + 7);
    check_v(ptick_edge[0]); check_v(ptick_edge[1]); check_v(fld(pc_a, 0));
    check_v(fld(bc_a, 0)); check_v(ptick_n[0]); check_v(ltick_n[1]);
    button_in = '0;
    wait_edge(edge_n + 10);

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drained observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
